// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if #(parameter int inst_SIZE = 16);
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_ctrl, req1_ctrl;
  logic [inst_SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [inst_SIZE-1:0] rsp0_data, rsp1_data;
  logic rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [2:0] alu_ctrl;
  logic [inst_SIZE-1:0] alu_in0, alu_in1, alu_out;
  logic alu_zero, busy;
  modport slave (
    input req0_valid, req1_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
    input rsp0_ready, rsp1_ready, alu_out, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, alu_ctrl, alu_in0, alu_in1, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_out, alu_zero,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, alu_ctrl, alu_in0, alu_in1, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters, one op in flight
module alu_arbiter #(parameter int inst_SIZE = 16) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, owner_q, owner_d, ill_q, ill_d, zero_q, zero_d, err_q, err_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [inst_SIZE-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic grant0, grant1, take, exec, rsp_hs, alu_en;
  always_comb begin
    grant0 = state_q == IDLE && bus.req0_valid && (!bus.req1_valid || !prio_q);
    grant1 = state_q == IDLE && bus.req1_valid && (!bus.req0_valid || prio_q);
    take = grant0 || grant1;
    exec = state_q == EXEC;
    rsp_hs = state_q == RESP && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
    alu_en = exec && !ill_q;
    state_d = take ? EXEC : exec ? RESP : rsp_hs ? IDLE : state_q;
    prio_d = rsp_hs ? !owner_q : prio_q;
    owner_d = take ? grant1 : owner_q;
    ctrl_d = take ? (grant1 ? bus.req1_ctrl : bus.req0_ctrl) : ctrl_q;
    a_d = take ? (grant1 ? bus.req1_a : bus.req0_a) : a_q;
    b_d = take ? (grant1 ? bus.req1_b : bus.req0_b) : b_q;
    ill_d = take ? ((grant1 ? bus.req1_ctrl : bus.req0_ctrl) >= 3'd5) : ill_q;
    data_d = exec ? (ill_q ? '0 : bus.alu_out) : data_q;
    zero_d = exec ? (!ill_q && bus.alu_zero) : zero_q;
    err_d = exec ? ill_q : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      owner_q <= 1'b0;
      ill_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
      ctrl_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      owner_q <= owner_d;
      ill_q <= ill_d;
      zero_q <= zero_d;
      err_q <= err_d;
      ctrl_q <= ctrl_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
    end
  end
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = state_q == RESP && !owner_q;
  assign bus.rsp1_valid = state_q == RESP && owner_q;
  assign bus.rsp0_data = bus.rsp0_valid ? data_q : '0;
  assign bus.rsp1_data = bus.rsp1_valid ? data_q : '0;
  assign bus.rsp0_zero = bus.rsp0_valid && zero_q;
  assign bus.rsp1_zero = bus.rsp1_valid && zero_q;
  assign bus.rsp0_err = bus.rsp0_valid && err_q;
  assign bus.rsp1_err = bus.rsp1_valid && err_q;
  assign bus.alu_ctrl = alu_en ? ctrl_q : 3'b000;
  assign bus.alu_in0 = alu_en ? a_q : '0;
  assign bus.alu_in1 = alu_en ? b_q : '0;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a transaction-level arbiter/ALU reference model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  bit done = 1'b0;
  typedef struct {bit owner; logic [2:0] ctrl; logic [15:0] a, b, data; bit zero, err;} exp_t;
  exp_t exp_q[$];
  int grant_log[$];
  bit m_busy = 1'b0;
  bit m_prio = 1'b0;
  int m_age = 0;
  alu_arbiter_if #(.inst_SIZE(16)) bus ();
  alu_arbiter #(.inst_SIZE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.alu_out = bus.alu_in0 + bus.alu_in1;
  assign bus.alu_zero = (bus.alu_in0 + bus.alu_in1) == 16'h0000;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic exp_t model(input bit n, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.owner = n; e.ctrl = c; e.a = a; e.b = b;
    e.err = c > 3'd4;
    e.data = e.err ? 16'h0 : 16'(a + b);
    e.zero = !e.err && e.data == 16'h0;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    bit v0, v1, g0, g1, lx;
    if (!rst_n) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_alu_ctrl", bus.alu_ctrl, 0);
      exp_q.delete();
      m_busy = 0; m_prio = 0; m_age = 0;
    end else begin
      e = m_busy ? exp_q[0] : model(0, 0, 0, 0);
      v0 = m_busy && m_age >= 2 && !e.owner;
      v1 = m_busy && m_age >= 2 && e.owner;
      lx = m_busy && m_age == 1 && !e.err;
      g0 = !m_busy && bus.req0_valid && (!bus.req1_valid || !m_prio);
      g1 = !m_busy && bus.req1_valid && (!bus.req0_valid || m_prio);
      chk("busy", bus.busy, m_busy);
      chk("rsp0_valid", bus.rsp0_valid, v0);
      chk("rsp1_valid", bus.rsp1_valid, v1);
      chk("rsp0_data", bus.rsp0_data, v0 ? e.data : 0);
      chk("rsp1_data", bus.rsp1_data, v1 ? e.data : 0);
      chk("rsp0_zero", bus.rsp0_zero, v0 && e.zero);
      chk("rsp1_zero", bus.rsp1_zero, v1 && e.zero);
      chk("rsp0_err", bus.rsp0_err, v0 && e.err);
      chk("rsp1_err", bus.rsp1_err, v1 && e.err);
      chk("alu_ctrl", bus.alu_ctrl, lx ? e.ctrl : 0);
      chk("alu_in0", bus.alu_in0, lx ? e.a : 0);
      chk("alu_in1", bus.alu_in1, lx ? e.b : 0);
      chk("req0_ready", bus.req0_ready, g0);
      chk("req1_ready", bus.req1_ready, g1);
      if (m_busy) begin
        if ((v0 && bus.rsp0_ready) || (v1 && bus.rsp1_ready)) begin
          m_prio = !e.owner;
          void'(exp_q.pop_front());
          m_busy = 0;
        end else if (m_age < 2) m_age++;
      end else if (g0 || g1) begin
        exp_q.push_back(g1 ? model(1, bus.req1_ctrl, bus.req1_a, bus.req1_b)
                           : model(0, bus.req0_ctrl, bus.req0_a, bus.req0_b));
        grant_log.push_back(g1 ? 1 : 0);
        m_busy = 1; m_age = 1;
      end
    end
  end
  task automatic issue(input bit n, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    if (n) begin bus.req1_valid = 1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b; end
    else begin bus.req0_valid = 1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n ? bus.req1_ready : bus.req0_ready) begin ok = 1; break; end
    end
    chk(n ? "accept1_timeout" : "accept0_timeout", ok, 1);
    @(posedge clk); #1;
    if (n) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic rand_loop(input bit n, input int cnt);
    logic [15:0] a;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      a = 16'($urandom);
      issue(n, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? 16'(-a) : 16'($urandom));
    end
  endtask
  initial begin
    {bus.req0_valid, bus.req1_valid, bus.rsp0_ready, bus.rsp1_ready} = '0;
    {bus.req0_ctrl, bus.req1_ctrl} = '0;
    {bus.req0_a, bus.req0_b, bus.req1_a, bus.req1_b} = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    issue(0, 3'b010, 16'h0001, 16'h00F2);
    chk("lat_exec_rsp0_valid", bus.rsp0_valid, 0);
    @(posedge clk); #1;
    chk("lat_rsp0_valid", bus.rsp0_valid, 1);
    chk("lat_rsp0_data", bus.rsp0_data, 16'h00F3);
    wait_idle();
    do_reset();
    grant_log.delete();
    fork
      issue(0, 3'b001, 16'h1234, 16'h0002);
      issue(1, 3'b000, 16'hFFFF, 16'h0001);
    join
    wait_idle();
    chk("contention_cnt", grant_log.size(), 2);
    chk("contention_first", grant_log[0], 0);
    chk("contention_second", grant_log[1], 1);
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) issue(0, 3'b011, 16'(i), 16'h0010);
      for (int i = 0; i < 3; i++) issue(1, 3'b100, 16'h0100, 16'(i));
    join
    wait_idle();
    chk("fair_cnt", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("fair_order", grant_log[i], i % 2);
    bus.rsp1_ready = 0;
    issue(1, 3'b010, 16'h4000, 16'h0123);
    fork
      issue(0, 3'b010, 16'h0005, 16'h0005);
      begin
        repeat (6) @(negedge clk);
        chk("bp_busy", bus.busy, 1);
        chk("bp_rsp1_valid", bus.rsp1_valid, 1);
        chk("bp_rsp1_data", bus.rsp1_data, 16'h4123);
        chk("bp_req0_ready", bus.req0_ready, 0);
        @(posedge clk); #1 bus.rsp1_ready = 1;
      end
    join
    wait_idle();
    issue(0, 3'b110, 16'h1111, 16'h2222);
    chk("ill_exec_alu_ctrl", bus.alu_ctrl, 0);
    chk("ill_exec_alu_in0", bus.alu_in0, 0);
    @(posedge clk); #1;
    chk("ill_rsp0_err", bus.rsp0_err, 1);
    chk("ill_rsp0_data", bus.rsp0_data, 0);
    wait_idle();
    bus.rsp0_ready = 0;
    issue(0, 3'b010, 16'h0005, 16'h0006);
    @(posedge clk); #1;
    chk("rr_rsp0_valid_before", bus.rsp0_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("rr_rsp0_valid_async", bus.rsp0_valid, 0);
    chk("rr_busy_async", bus.busy, 0);
    @(posedge clk); #2 rst_n = 1; bus.rsp0_ready = 1;
    repeat (4) begin @(negedge clk); chk("rr_no_rsp", bus.rsp0_valid, 0); end
    @(posedge clk); #1;
    fork
      begin
        fork
          rand_loop(0, 30);
          rand_loop(1, 30);
        join
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        wait_idle();
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        if (!done) begin
          bus.rsp0_ready = 1'($urandom_range(0, 1));
          bus.rsp1_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
